regfile_debug_port: RTL

Debug-side initiator for the eLC-3 general-purpose register file. Accepts read, write, and dump-all commands over a valid/ready command channel while the CPU is halted. It drives the register file's DR/SR1/LD_REG/In lines and returns register contents over a valid/ready response channel. It sits between the debug host interface (UART/JTAG bridge) and the datapath mux that grants register file ownership.

---
 rtl/elc3_debug_pkg.sv | 22 ++
 rtl/regfile_debug_port.sv | 130 +++++++++++++
 2 files changed

// File: rtl/elc3_debug_pkg.sv
// Shared types and constants for the eLC-3 register-file debug port.
package elc3_debug_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS = 8;
   localparam logic [2:0] LAST_REG = 3'(NREGS - 1);

   typedef enum logic [1:0] {
      OP_NOP,
      OP_READ,
      OP_WRITE,
      OP_DUMP
   } debug_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_RSP,
      S_WR
   } dbg_state_t;

endpackage

// File: rtl/regfile_debug_port.sv
// Debug-side initiator for the eLC-3 register file: read, write and
// dump-all commands while the CPU is halted.
module regfile_debug_port
   import elc3_debug_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Halted,
   input  logic              Cmd_Valid,
   output logic              Cmd_Ready,
   input  logic [1:0]        Cmd_Op,
   input  logic [2:0]        Cmd_Reg,
   input  logic [DATA_W-1:0] Cmd_Data,
   output logic              Rsp_Valid,
   input  logic              Rsp_Ready,
   output logic [2:0]        Rsp_Reg,
   output logic [DATA_W-1:0] Rsp_Data,
   output logic              Busy,
   output logic              Owns_RF,
   output logic              RF_LD_REG,
   output logic [2:0]        RF_DR,
   output logic [2:0]        RF_SR1,
   output logic [DATA_W-1:0] RF_In,
   input  logic [DATA_W-1:0] RF_SR1_Out
);

   dbg_state_t        state;
   logic [2:0]        idx;
   logic              dump;
   logic              owns;
   logic              rsp_valid;
   logic [2:0]        rsp_reg;
   logic [DATA_W-1:0] rsp_data;
   logic              rf_ld;
   logic [2:0]        rf_dr;
   logic [2:0]        rf_sr1;
   logic [DATA_W-1:0] rf_in;
   logic              accept;

   assign Cmd_Ready = Reset & Halted & (state == S_IDLE);
   assign accept    = Cmd_Valid & Cmd_Ready;

   assign Rsp_Valid = rsp_valid;
   assign Rsp_Reg   = rsp_reg;
   assign Rsp_Data  = rsp_data;
   assign Busy      = owns;
   assign Owns_RF   = owns;
   assign RF_LD_REG = rf_ld;
   assign RF_DR     = rf_dr;
   assign RF_SR1    = rf_sr1;
   assign RF_In     = rf_in;

   // Register-file controls are one-cycle registered pulses; they default
   // back to zero every cycle and are set only on entry to RD or WR.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         dump      <= 1'b0;
         owns      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_reg   <= '0;
         rsp_data  <= '0;
         rf_ld     <= 1'b0;
         rf_dr     <= '0;
         rf_sr1    <= '0;
         rf_in     <= '0;
      end else begin
         rf_ld  <= 1'b0;
         rf_dr  <= '0;
         rf_in  <= '0;
         rf_sr1 <= '0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  unique case (debug_op_t'(Cmd_Op))
                     OP_READ: begin
                        idx    <= Cmd_Reg;
                        dump   <= 1'b0;
                        rf_sr1 <= Cmd_Reg;
                        owns   <= 1'b1;
                        state  <= S_RD;
                     end
                     OP_WRITE: begin
                        rf_ld <= 1'b1;
                        rf_dr <= Cmd_Reg;
                        rf_in <= Cmd_Data;
                        owns  <= 1'b1;
                        state <= S_WR;
                     end
                     OP_DUMP: begin
                        idx    <= '0;
                        dump   <= 1'b1;
                        rf_sr1 <= '0;
                        owns   <= 1'b1;
                        state  <= S_RD;
                     end
                     OP_NOP: ;
                  endcase
               end
            end
            S_RD: begin
               rsp_data  <= RF_SR1_Out;
               rsp_reg   <= idx;
               rsp_valid <= 1'b1;
               state     <= S_RSP;
            end
            S_RSP: begin
               if (Rsp_Ready) begin
                  rsp_valid <= 1'b0;
                  // A dump stops at the last register instead of wrapping.
                  if (dump && idx != LAST_REG) begin
                     idx    <= idx + 3'd1;
                     rf_sr1 <= idx + 3'd1;
                     state  <= S_RD;
                  end else begin
                     owns  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
            end
            S_WR: begin
               owns  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
